sram_mem_arbiter: RTL and testbench
===================================

// Module: sram_mem_arbiter
// PURPOSE
//  Shares one external 16-bit asynchronous SRAM between the IF-stage instruction port and the MEM-stage LSU data port.
//  - Arbitrates between the two requesters.
//  - Splits each 32-bit word access into two halfword SRAM phases (LO, then HI).
//  - Drives the SRAM pins and returns a one-cycle ack per access.
//  The HDU holds the pipeline on the ack signals: IF stalls until o_if_ack, MEM stalls until o_lsu_ack.
// PARAMETERS
//  PHASE_CYC  2   cycles per halfword phase; must be >= 2 (setup + strobe)
//  ADDR_W     18  SRAM halfword address width
// PORTS
//  i_clk        in    1       clock, rising edge
//  i_rstn       in    1       reset, asynchronous, active-low
//  i_if_req     in    1       IF read request; held high until o_if_ack
//  i_if_addr    in    32      IF byte address (bits [1:0] ignored)
//  o_if_rdata   out   32      IF read word; valid in the o_if_ack cycle
//  o_if_ack     out   1       one-cycle IF completion pulse
//  i_lsu_req    in    1       LSU request; held high until o_lsu_ack
//  i_lsu_wren   in    1       1 = write, 0 = read
//  i_lsu_addr   in    32      LSU byte address (bits [1:0] ignored)
//  i_lsu_bmask  in    4       write byte enables, bit n = byte n
//  i_lsu_wdata  in    32      write word
//  o_lsu_rdata  out   32      LSU read word; valid in the o_lsu_ack cycle
//  o_lsu_ack    out   1       one-cycle LSU completion pulse
//  o_sram_addr  out   ADDR_W  halfword address
//  io_sram_dq   inout 16      SRAM data bus
//  o_sram_ce_n, o_sram_oe_n, o_sram_we_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active-low
// BEHAVIOUR
//  Reset (async, any state): FSM -> IDLE.
//  - All strobes are high; dq is high-Z.
//  - o_sram_addr = 0, both acks = 0, both rdata = 0.
//  - Any in-flight access is abandoned with no ack.
//  FSM states: IDLE -> LO -> HI -> DONE -> IDLE.
//  - A per-phase counter counts 0..PHASE_CYC-1; the FSM advances when the counter reaches PHASE_CYC-1.
//  IDLE: arbitrate each cycle.
//  - Fixed priority: LSU over IF (MEM holds the older instruction).
//  - Grant latches the requester id, wren, address, bmask and wdata; the FSM then enters LO.
//  - IF is always treated as a read, with bmask = 4'hF.
//  Addressing:
//  - LO phase: o_sram_addr = {addr[ADDR_W:2], 1'b0}.
//  - HI phase: o_sram_addr = {addr[ADDR_W:2], 1'b1}.
//  - Address bits above ADDR_W are ignored (the LSU decodes the region upstream).
//  Read phase: ce_n = 0, oe_n = 0, we_n = 1, lb_n = ub_n = 0, dq is high-Z.
//  - dq is captured on the last phase cycle: LO -> rdata[15:0], HI -> rdata[31:16].
//  Write phase: ce_n = 0, oe_n = 1, dq driven for the whole phase.
//  - Data: wdata[15:0] in LO, wdata[31:16] in HI.
//  - we_n = 0 on phase cycles 0..PHASE_CYC-2 and 1 on the last cycle (data hold).
//  - Lane enables: lb_n/ub_n = ~bmask[0]/~bmask[1] in LO, ~bmask[2]/~bmask[3] in HI.
//  - A write phase whose two mask bits are both 0 is skipped entirely: no strobe, zero cycles.
//  - Mask 0 skips both phases; the FSM goes straight to DONE.
//  DONE: pulse the granted requester's ack for exactly one cycle and present rdata, then return to IDLE.
//  - rdata holds its value until the next read to that port completes.
//  Latency from a request seen in IDLE to the ack:
//  - Full access: 2*PHASE_CYC + 1 cycles (5 at the default).
//  - Single-phase write: PHASE_CYC + 1 cycles.
//  - Zero-mask write: 1 cycle.
//  Handshake rules:
//  - The requester must keep req and its inputs stable until ack.
//  - In the cycle after ack, the requester deasserts req or presents a new request.
//  - The arbiter re-arbitrates in IDLE, so there is at least one idle cycle between accesses.
//  - Simultaneous requests in IDLE: LSU is granted; IF stays pending and is granted in the next IDLE if LSU req is low.
//  - A request arriving while busy waits; there is no preemption.
//  Between phases ce_n stays 0. Strobes return high in DONE and IDLE.
//  dq is driven only in write phases: no contention when switching between read and write.
// TESTING
//  1 Reset mid-write: assert i_rstn=0 in the HI phase -> strobes=1 and dq=Z immediately; no ack after release.
//  2 IF read of addr 0x10, SRAM holds [0x8]=0xBEEF, [0x9]=0xDEAD -> o_if_ack 5 cycles later, o_if_rdata=0xDEADBEEF.
//  3 LSU write of 0x12345678 to 0x20, bmask=4'hF -> LO drives 0x5678 at addr 0x10, HI drives 0x1234 at addr 0x11.
//    - we_n low only on cycle 0 of each phase; ack at cycle 5.
//  4 LSU write with bmask=4'b0100 -> LO skipped; HI has lb_n=0, ub_n=1; ack at cycle 3.
//    - bmask=0 -> no strobe, ack at cycle 1.
//  5 i_if_req and i_lsu_req asserted in the same cycle -> LSU acked at cycle 5, IF acked at cycle 11.
//    - No dq contention at any point.
//  6 Back-to-back LSU read then write -> one idle cycle between them; dq stays Z until the write's LO phase.

Source files
------------

// File: rtl/sram_mem_arbiter.sv
// rtl/sram_mem_arbiter.sv - shares one 16-bit async SRAM between the IF and LSU ports
module sram_mem_arbiter #(
  parameter int PHASE_CYC = 2,
  parameter int ADDR_W    = 18
) (
  input  logic              i_clk,
  input  logic              i_rstn,
  input  logic              i_if_req,
  input  logic [31:0]       i_if_addr,
  output logic [31:0]       o_if_rdata,
  output logic              o_if_ack,
  input  logic              i_lsu_req,
  input  logic              i_lsu_wren,
  input  logic [31:0]       i_lsu_addr,
  input  logic [3:0]        i_lsu_bmask,
  input  logic [31:0]       i_lsu_wdata,
  output logic [31:0]       o_lsu_rdata,
  output logic              o_lsu_ack,
  output logic [ADDR_W-1:0] o_sram_addr,
  inout  wire  [15:0]       io_sram_dq,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PHASE_CYC - 1);

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              sel_lsu;
  logic              wren;
  logic [ADDR_W-2:0] waddr;
  logic [3:0]        bmask;
  logic [31:0]       wdata;
  logic [15:0]       lo_buf;
  logic              dq_oe;
  logic [15:0]       dq_out;
  logic              phase_last;
  logic              any_req;
  logic              req_wren;
  logic [3:0]        req_bmask;
  logic              unused_addr_bits;

  // Only the halfword-addressable bits of each byte address reach the SRAM.
  assign unused_addr_bits = ^{i_if_addr[31:ADDR_W+1], i_if_addr[1:0],
                              i_lsu_addr[31:ADDR_W+1], i_lsu_addr[1:0]};

  assign phase_last = (cnt == CNT_LAST);
  assign any_req    = i_lsu_req | i_if_req;
  // LSU wins arbitration; IF is always a full-word read.
  assign req_wren   = i_lsu_req & i_lsu_wren;
  assign req_bmask  = i_lsu_req ? i_lsu_bmask : 4'hF;

  assign io_sram_dq = dq_oe ? dq_out : 16'bz;

  // State register and per-phase cycle counter.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if ((state_nxt == state) && ((state == LO) || (state == HI)))
        cnt <= cnt + 1'b1;
      else
        cnt <= '0;
    end
  end

  // Latch the granted access when leaving IDLE.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      sel_lsu <= 1'b0;
      wren    <= 1'b0;
      waddr   <= '0;
      bmask   <= 4'h0;
      wdata   <= '0;
    end else if ((state == IDLE) && any_req) begin
      sel_lsu <= i_lsu_req;
      wren    <= req_wren;
      waddr   <= i_lsu_req ? i_lsu_addr[ADDR_W:2] : i_if_addr[ADDR_W:2];
      bmask   <= req_bmask;
      wdata   <= i_lsu_req ? i_lsu_wdata : 32'h0;
    end
  end

  // Capture read halves on the last cycle of each phase; rdata holds until the next read.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      lo_buf      <= '0;
      o_if_rdata  <= '0;
      o_lsu_rdata <= '0;
    end else if (!wren && phase_last) begin
      if (state == LO) begin
        lo_buf <= io_sram_dq;
      end else if (state == HI) begin
        if (sel_lsu) o_lsu_rdata <= {io_sram_dq, lo_buf};
        else         o_if_rdata  <= {io_sram_dq, lo_buf};
      end
    end
  end

  // Next-state selection, phase skipping for masked-off writes, and SRAM pin drive.
  always_comb begin
    state_nxt   = state;
    o_sram_addr = '0;
    o_sram_ce_n = 1'b1;
    o_sram_oe_n = 1'b1;
    o_sram_we_n = 1'b1;
    o_sram_lb_n = 1'b1;
    o_sram_ub_n = 1'b1;
    dq_oe       = 1'b0;
    dq_out      = '0;
    o_if_ack    = 1'b0;
    o_lsu_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          if (req_wren && (req_bmask[1:0] == 2'b00))
            state_nxt = (req_bmask[3:2] == 2'b00) ? DONE : HI;
          else
            state_nxt = LO;
        end
      end
      LO, HI: begin
        o_sram_ce_n = 1'b0;
        o_sram_addr = {waddr, (state == HI)};
        if (wren) begin
          o_sram_we_n = phase_last;
          dq_oe       = 1'b1;
          if (state == LO) begin
            o_sram_lb_n = ~bmask[0];
            o_sram_ub_n = ~bmask[1];
            dq_out      = wdata[15:0];
          end else begin
            o_sram_lb_n = ~bmask[2];
            o_sram_ub_n = ~bmask[3];
            dq_out      = wdata[31:16];
          end
        end else begin
          o_sram_oe_n = 1'b0;
          o_sram_lb_n = 1'b0;
          o_sram_ub_n = 1'b0;
        end
        if (phase_last) begin
          if (state == LO)
            state_nxt = (wren && (bmask[3:2] == 2'b00)) ? DONE : HI;
          else
            state_nxt = DONE;
        end
      end
      DONE: begin
        o_lsu_ack = sel_lsu;
        o_if_ack  = ~sel_lsu;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// tb/tb_sram_mem_arbiter.sv - scoreboard bench for sram_mem_arbiter with SRAM model
module tb_sram_mem_arbiter;

  localparam int PC = 2;
  localparam int AW = 18;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          if_req = 1'b0;
  logic [31:0]   if_addr = '0;
  logic [31:0]   if_rdata;
  logic          if_ack;
  logic          lsu_req = 1'b0;
  logic          lsu_wren = 1'b0;
  logic [31:0]   lsu_addr = '0;
  logic [3:0]    lsu_bmask = '0;
  logic [31:0]   lsu_wdata = '0;
  logic [31:0]   lsu_rdata;
  logic          lsu_ack;
  logic [AW-1:0] sram_addr;
  wire  [15:0]   dq;
  logic          ce_n, oe_n, we_n, lb_n, ub_n;

  int checks = 0;
  int errors = 0;
  int contention = 0;

  typedef struct {
    logic [31:0] data;
    bit          is_read;
  } exp_t;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we_n;
    logic          oe_n;
    logic          lb_n;
    logic          ub_n;
    logic [15:0]   dq;
  } tr_t;

  exp_t        if_q[$];
  exp_t        lsu_q[$];
  exp_t        mon_e;
  tr_t         trace[$];
  logic [31:0] if_last = '0;
  logic [31:0] lsu_last = '0;

  logic [15:0] sram    [0:(1<<AW)-1];
  logic [15:0] ref_mem [0:(1<<AW)-1];

  sram_mem_arbiter #(.PHASE_CYC(PC), .ADDR_W(AW)) dut (
    .i_clk(clk), .i_rstn(rstn),
    .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_ack(if_ack),
    .i_lsu_req(lsu_req), .i_lsu_wren(lsu_wren), .i_lsu_addr(lsu_addr),
    .i_lsu_bmask(lsu_bmask), .i_lsu_wdata(lsu_wdata),
    .o_lsu_rdata(lsu_rdata), .o_lsu_ack(lsu_ack),
    .o_sram_addr(sram_addr), .io_sram_dq(dq),
    .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n), .o_sram_we_n(we_n),
    .o_sram_lb_n(lb_n), .o_sram_ub_n(ub_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM device: drives on output enable, writes enabled lanes while we_n is low.
  assign dq = (!ce_n && !oe_n && we_n) ? sram[sram_addr] : 16'bz;

  always @(negedge clk) begin
    if (!ce_n && !we_n) begin
      if (!lb_n) sram[sram_addr][7:0]  <= dq[7:0];
      if (!ub_n) sram[sram_addr][15:8] <= dq[15:8];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Pin trace and contention watch.
  always @(negedge clk) begin
    if (rstn && !ce_n) begin
      trace.push_back('{addr: sram_addr, we_n: we_n, oe_n: oe_n, lb_n: lb_n, ub_n: ub_n, dq: dq});
      if (!oe_n && !we_n) contention++;
    end
  end

  // Scoreboard monitor: every ack pops its port's oldest expectation.
  always @(negedge clk) begin
    if (rstn && lsu_ack) begin
      if (lsu_q.size() == 0) check("lsu_unexpected_ack", 1, 0);
      else begin
        mon_e = lsu_q.pop_front();
        if (mon_e.is_read) begin
          check("lsu_rdata", lsu_rdata, mon_e.data);
          lsu_last = mon_e.data;
        end else check("lsu_rdata_hold", lsu_rdata, lsu_last);
      end
    end
    if (rstn && if_ack) begin
      if (if_q.size() == 0) check("if_unexpected_ack", 1, 0);
      else begin
        mon_e = if_q.pop_front();
        check("if_rdata", if_rdata, mon_e.data);
        if_last = mon_e.data;
      end
    end
  end

  function automatic logic [31:0] ref_word(input int w);
    return {ref_mem[2*w+1], ref_mem[2*w]};
  endfunction

  task automatic ref_write(input int w, input logic [3:0] m, input logic [31:0] d);
    if (m[0]) ref_mem[2*w][7:0]    = d[7:0];
    if (m[1]) ref_mem[2*w][15:8]   = d[15:8];
    if (m[2]) ref_mem[2*w+1][7:0]  = d[23:16];
    if (m[3]) ref_mem[2*w+1][15:8] = d[31:24];
  endtask

  // Called just after a rising edge; returns cycles from the request cycle to the ack cycle.
  task automatic lsu_op(input logic wr, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, output int lat);
    exp_t e;
    int   w;
    bit   done;
    w = int'(a[AW:2]);
    e.is_read = !wr;
    e.data    = ref_word(w);
    lsu_q.push_back(e);
    if (wr) ref_write(w, m, d);
    lsu_req = 1'b1; lsu_wren = wr; lsu_addr = a; lsu_bmask = m; lsu_wdata = d;
    lat = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (lsu_ack) done = 1;
      else begin
        lat++;
        if (lat > 100) begin check("lsu_ack_timeout", 0, 1); done = 1; end
      end
    end
    @(posedge clk); #1;
    lsu_req = 1'b0;
  endtask

  task automatic if_op(input logic [31:0] a, output int lat);
    exp_t e;
    bit   done;
    e.is_read = 1'b1;
    e.data    = ref_word(int'(a[AW:2]));
    if_q.push_back(e);
    if_req = 1'b1; if_addr = a;
    lat = 0; done = 0;
    while (!done) begin
      @(negedge clk);
      if (if_ack) done = 1;
      else begin
        lat++;
        if (lat > 100) begin check("if_ack_timeout", 0, 1); done = 1; end
      end
    end
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr(input int w);
    return ($urandom & 32'hFFF8_0003) | (32'(w) << 2);
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, acks, mism;
    tr_t t;
    for (int i = 0; i < 4096; i++) begin
      sram[i]    = 16'($urandom);
      ref_mem[i] = sram[i];
    end
    sram[8] = 16'hBEEF; ref_mem[8] = 16'hBEEF;
    sram[9] = 16'hDEAD; ref_mem[9] = 16'hDEAD;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
    check("rst_addr", sram_addr, 0);
    check("rst_acks", {if_ack, lsu_ack}, 0);
    check("rst_rdata", {if_rdata, lsu_rdata}, 0);
    rstn = 1'b1;
    @(posedge clk); #1;

    // Reset in the HI phase of a write: strobes release at once, no ack afterwards.
    lsu_req = 1'b1; lsu_wren = 1'b1; lsu_addr = 32'h0000_FFC0; lsu_bmask = 4'hF; lsu_wdata = 32'hA5A5_5A5A;
    repeat (4) @(negedge clk);
    check("rst_mid_in_hi", sram_addr, 18'h07FE1);
    rstn = 1'b0;
    #1;
    check("rst_mid_strobes", {ce_n, oe_n, we_n, lb_n, ub_n}, 5'b11111);
    check("rst_mid_addr", sram_addr, 0);
    lsu_req = 1'b0;
    @(posedge clk); #1;
    rstn = 1'b1;
    acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (lsu_ack || if_ack) acks++;
    end
    check("rst_mid_no_ack", acks, 0);
    @(posedge clk); #1;

    // IF read of 0x10.
    if_op(32'h0000_0010, lat);
    check("if_read_lat", lat, 2*PC+1);
    check("if_read_data", if_rdata, 32'hDEAD_BEEF);

    // Full write, phase pin sequence.
    trace.delete();
    lsu_op(1'b1, 32'h0000_0020, 4'hF, 32'h1234_5678, lat);
    check("wr_full_lat", lat, 2*PC+1);
    check("wr_full_ncyc", trace.size(), 4);
    if (trace.size() == 4) begin
      t = trace[0]; check("wr_full_c0", {t.addr, t.we_n, t.oe_n, t.lb_n, t.ub_n, t.dq}, {18'h10, 4'b0100, 16'h5678});
      t = trace[1]; check("wr_full_c1", {t.addr, t.we_n, t.oe_n, t.lb_n, t.ub_n, t.dq}, {18'h10, 4'b1100, 16'h5678});
      t = trace[2]; check("wr_full_c2", {t.addr, t.we_n, t.oe_n, t.lb_n, t.ub_n, t.dq}, {18'h11, 4'b0100, 16'h1234});
      t = trace[3]; check("wr_full_c3", {t.addr, t.we_n, t.oe_n, t.lb_n, t.ub_n, t.dq}, {18'h11, 4'b1100, 16'h1234});
    end

    // Single-lane write: LO skipped.
    trace.delete();
    lsu_op(1'b1, 32'h0000_0040, 4'b0100, 32'hCAFE_F00D, lat);
    check("wr_hi_only_lat", lat, PC+1);
    check("wr_hi_only_ncyc", trace.size(), 2);
    if (trace.size() == 2) begin
      t = trace[0]; check("wr_hi_only_c0", {t.addr, t.we_n, t.oe_n, t.lb_n, t.ub_n, t.dq}, {18'h21, 4'b0101, 16'hCAFE});
    end

    // LO-only write: HI skipped.
    trace.delete();
    lsu_op(1'b1, 32'h0000_0048, 4'b0011, 32'h0BAD_BEAD, lat);
    check("wr_lo_only_lat", lat, PC+1);
    check("wr_lo_only_ncyc", trace.size(), 2);

    // Zero-mask write: no strobes at all.
    trace.delete();
    lsu_op(1'b1, 32'h0000_0044, 4'b0000, 32'hFFFF_FFFF, lat);
    check("wr_zero_lat", lat, 1);
    check("wr_zero_ncyc", trace.size(), 0);

    // Simultaneous requests: LSU first, IF after one more access slot.
    fork
      lsu_op(1'b0, 32'h0000_0040, 4'hF, 32'h0, lat);
      if_op(32'h0000_0030, lat2);
    join
    check("both_lsu_lat", lat, 2*PC+1);
    check("both_if_lat", lat2, 4*PC+3);

    // Back-to-back LSU read then write.
    trace.delete();
    lsu_op(1'b0, 32'h0000_0020, 4'hF, 32'h0, lat);
    lsu_op(1'b1, 32'h0000_0050, 4'hF, 32'h7777_8888, lat2);
    check("b2b_read_lat", lat, 2*PC+1);
    check("b2b_write_lat", lat2, 2*PC+1);
    check("b2b_ncyc", trace.size(), 8);
    if (trace.size() == 8) begin
      check("b2b_read_oe", {trace[0].oe_n, trace[1].oe_n, trace[2].oe_n, trace[3].oe_n}, 4'b0000);
      check("b2b_write_oe", {trace[4].oe_n, trace[5].oe_n, trace[6].oe_n, trace[7].oe_n}, 4'b1111);
    end
    lsu_op(1'b0, 32'h0000_0048, 4'hF, 32'h0, lat);

    // Randomized traffic: IF reads words 0..0x1FF, LSU reads/writes words 0x200..0x3FF.
    fork
      begin
        int l;
        for (int i = 0; i < 120; i++) begin
          if_op(rand_addr($urandom_range(0, 16'h1FF)), l);
          if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
      end
      begin
        int l;
        for (int i = 0; i < 160; i++) begin
          lsu_op(1'($urandom_range(0, 1)), rand_addr($urandom_range(16'h200, 16'h3FF)),
                 4'($urandom), $urandom, l);
          if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
          end
        end
      end
    join

    repeat (4) @(posedge clk);
    mism = 0;
    for (int i = 0; i < 2048; i++) if (sram[i] !== ref_mem[i]) mism++;
    check("mem_final_mismatches", mism, 0);
    check("no_contention", contention, 0);
    check("sb_drained", if_q.size() + lsu_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
